// File: rtl/bike_motion_engine.sv
// bike_motion_engine: steps one bike sprite across the field, filters turns, latches crashes
module bike_motion_engine #(
    parameter int START_X     = 100,
    parameter int START_Y     = 200,
    parameter int START_DIR   = 4,
    parameter int STEP_DIV    = 500000,
    parameter int STEP_PX     = 1,
    parameter int GRACE_TICKS = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        respawn,
    input  logic [3:0]  dir_req,
    input  logic        crash_in,
    output logic [31:0] pos_addr,
    output logic [31:0] orient,
    output logic        alive,
    output logic        crashed,
    output logic        move_strobe
);
    localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int GW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
    localparam logic [GW-1:0] GRACE_LD = GW'(GRACE_TICKS);
    localparam logic [9:0] SX = 10'(START_X);
    localparam logic [8:0] SY = 9'(START_Y);
    localparam logic [2:0] SD = 3'(START_DIR);
    localparam logic [9:0] STEP_X = 10'(STEP_PX);
    localparam logic [8:0] STEP_Y = 9'(STEP_PX);
    localparam logic [9:0] X_MAX = 10'd609;
    localparam logic [8:0] Y_MAX = 9'd449;
    localparam logic [31:0] START_ADDR = 32'(START_Y * 640 + START_X);
    localparam logic [2:0] D_UP = 3'd1, D_DN = 3'd2, D_LT = 3'd3, D_RT = 3'd4;

    typedef enum logic [1:0] {IDLE, RUN, CRASHED} state_t;

    state_t          state, state_nx;
    logic [DW-1:0]   div;
    logic [GW-1:0]   grace;
    logic [9:0]      x, nx;
    logic [8:0]      y, ny;
    logic [2:0]      dir, pending, pending_nx, req, ref_dir;
    logic            tick, crash_hit, bound_hit, do_move, start_run, moved;

    function automatic logic is_rev(input logic [2:0] a, input logic [2:0] b);
        return (a == D_UP && b == D_DN) || (a == D_DN && b == D_UP) ||
               (a == D_LT && b == D_RT) || (a == D_RT && b == D_LT);
    endfunction

    assign start_run = state == IDLE && enable;
    assign tick      = state == RUN && enable && div == DIV_MAX;
    assign crash_hit = state == RUN && crash_in && grace == '0;
    assign do_move   = tick && !crash_hit && !bound_hit;
    assign orient    = {29'd0, dir};

    // Resolve the requested turn and the move it implies on the next tick
    always_comb begin
        req        = dir_req[3] ? D_UP : dir_req[2] ? D_DN : dir_req[1] ? D_LT : dir_req[0] ? D_RT : 3'd0;
        ref_dir    = tick ? pending : dir;
        pending_nx = (req != 3'd0 && !is_rev(req, ref_dir)) ? req : pending;
        bound_hit  = pending == D_UP ? (y < STEP_Y) :
                     pending == D_DN ? (y > Y_MAX - STEP_Y) :
                     pending == D_LT ? (x < STEP_X) :
                     pending == D_RT ? (x > X_MAX - STEP_X) : 1'b0;
        nx         = pending == D_LT ? x - STEP_X : pending == D_RT ? x + STEP_X : x;
        ny         = pending == D_UP ? y - STEP_Y : pending == D_DN ? y + STEP_Y : y;
        state_nx   = start_run ? RUN : (crash_hit || (tick && bound_hit)) ? CRASHED : state;
    end

    // State, divider, grace window, direction and position registers
    always_ff @(posedge clock) begin
        if (reset || respawn) begin
            state   <= IDLE;
            div     <= '0;
            grace   <= '0;
            x       <= SX;
            y       <= SY;
            dir     <= SD;
            pending <= SD;
            moved   <= 1'b0;
            alive   <= 1'b0;
            crashed <= 1'b0;
        end else begin
            state   <= state_nx;
            alive   <= state_nx == RUN;
            crashed <= state_nx == CRASHED;
            div     <= (start_run || tick) ? '0 : (state == RUN && enable) ? div + DW'(1) : div;
            grace   <= start_run ? GRACE_LD : (tick && grace != '0) ? grace - GW'(1) : grace;
            pending <= pending_nx;
            moved   <= do_move;
            if (tick && !crash_hit)
                dir <= pending;
            if (do_move) begin
                x <= nx;
                y <= ny;
            end
        end
    end

    // Linear address and move strobe, one stage behind the position registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_addr    <= START_ADDR;
            move_strobe <= 1'b0;
        end else begin
            pos_addr    <= 32'(y) * 32'd640 + 32'(x);
            move_strobe <= moved;
        end
    end
endmodule

// File: tb/tb_bike_motion_engine.sv
// tb_bike_motion_engine: directed checks of motion, turning, crashes, respawn and pause
module tb_bike_motion_engine;
    logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, respawn = 1'b0, crash_in = 1'b0, en_b = 1'b0;
    logic [3:0]  dir_req = 4'd0;
    logic [31:0] pos_addr, orient, b_pos, b_orient;
    logic        alive, crashed, move_strobe, b_alive, b_crashed, b_strobe;
    int          total = 0, bad = 0;

    always #5 clock = ~clock;

    bike_motion_engine #(.START_X(100), .START_Y(200), .START_DIR(4), .STEP_DIV(4), .STEP_PX(1), .GRACE_TICKS(2)) u_main (
        .clock(clock), .reset(reset), .enable(enable), .respawn(respawn), .dir_req(dir_req), .crash_in(crash_in),
        .pos_addr(pos_addr), .orient(orient), .alive(alive), .crashed(crashed), .move_strobe(move_strobe));

    bike_motion_engine #(.START_X(609), .START_Y(200), .START_DIR(4), .STEP_DIV(4), .STEP_PX(1), .GRACE_TICKS(2)) u_edge (
        .clock(clock), .reset(reset), .enable(en_b), .respawn(1'b0), .dir_req(4'd0), .crash_in(1'b0),
        .pos_addr(b_pos), .orient(b_orient), .alive(b_alive), .crashed(b_crashed), .move_strobe(b_strobe));

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (move_strobe !== 1'b1 && n < max);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (pos_addr !== 32'd128100) begin bad++; $display("FAIL reset_pos got=%0d want=128100", pos_addr); end
        total++; if (orient !== 32'd4) begin bad++; $display("FAIL reset_orient got=%0d want=4", orient); end
        total++; if ({alive, crashed, move_strobe} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {alive, crashed, move_strobe}); end
        total++; if (b_pos !== 32'd128609) begin bad++; $display("FAIL reset_edge_pos got=%0d want=128609", b_pos); end
    endtask

    task automatic test_boundary;
        int err;
        en_b = 1'b1;
        repeat (4) step();
        total++; if ({b_alive, b_crashed} !== 2'b10) begin bad++; $display("FAIL bound_pre got=%b want=10", {b_alive, b_crashed}); end
        step();
        total++; if ({b_alive, b_crashed} !== 2'b01) begin bad++; $display("FAIL bound_crash got=%b want=01", {b_alive, b_crashed}); end
        err = 0;
        repeat (12) begin
            step();
            if (b_strobe !== 1'b0 || b_pos !== 32'd128609) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL bound_frozen got=%0d bad cycles want=0 (pos=%0d)", err, b_pos); end
        total++; if (b_orient !== 32'd4) begin bad++; $display("FAIL bound_orient got=%0d want=4", b_orient); end
    endtask

    task automatic test_first_step;
        int n;
        enable = 1'b1;
        wait_strobe(20, n);
        total++; if (n != 6) begin bad++; $display("FAIL first_latency got=%0d want=6", n); end
        total++; if (pos_addr !== 32'd128101) begin bad++; $display("FAIL first_pos got=%0d want=128101", pos_addr); end
        step();
        total++; if (move_strobe !== 1'b0) begin bad++; $display("FAIL first_single_strobe got=%b want=0", move_strobe); end
    endtask

    task automatic test_turn;
        int n;
        dir_req = 4'b0010;
        wait_strobe(20, n);
        total++; if (n != 3 || pos_addr !== 32'd128102) begin bad++; $display("FAIL reverse_pos got=%0d n=%0d want=128102 n=3", pos_addr, n); end
        total++; if (orient !== 32'd4) begin bad++; $display("FAIL reverse_orient got=%0d want=4", orient); end
        dir_req = 4'b1000;
        step();
        dir_req = 4'b0000;
        wait_strobe(20, n);
        total++; if (orient !== 32'd1) begin bad++; $display("FAIL turn_orient got=%0d want=1", orient); end
        total++; if (n != 3 || pos_addr !== 32'd127462) begin bad++; $display("FAIL turn_pos got=%0d n=%0d want=127462 n=3", pos_addr, n); end
        wait_strobe(20, n);
        total++; if (n != 4 || pos_addr !== 32'd126822) begin bad++; $display("FAIL hold_dir_pos got=%0d n=%0d want=126822 n=4", pos_addr, n); end
    endtask

    task automatic test_respawn_priority;
        enable = 1'b0;
        respawn = 1'b1;
        crash_in = 1'b1;
        step();
        respawn = 1'b0;
        crash_in = 1'b0;
        total++; if ({alive, crashed} !== 2'b00) begin bad++; $display("FAIL respawn_flags got=%b want=00", {alive, crashed}); end
        step();
        total++; if (pos_addr !== 32'd128100) begin bad++; $display("FAIL respawn_pos got=%0d want=128100", pos_addr); end
        total++; if (orient !== 32'd4) begin bad++; $display("FAIL respawn_orient got=%0d want=4", orient); end
        repeat (3) step();
        total++; if ({alive, crashed} !== 2'b00) begin bad++; $display("FAIL respawn_idle got=%b want=00", {alive, crashed}); end
    endtask

    task automatic test_grace;
        int n, err;
        enable = 1'b1;
        wait_strobe(20, n);
        total++; if (n != 6 || pos_addr !== 32'd128101) begin bad++; $display("FAIL grace_tick1 got=%0d n=%0d want=128101 n=6", pos_addr, n); end
        crash_in = 1'b1;
        step();
        crash_in = 1'b0;
        total++; if ({alive, crashed} !== 2'b10) begin bad++; $display("FAIL grace_ignore got=%b want=10", {alive, crashed}); end
        wait_strobe(20, n);
        total++; if (n != 3 || pos_addr !== 32'd128102) begin bad++; $display("FAIL grace_tick2 got=%0d n=%0d want=128102 n=3", pos_addr, n); end
        crash_in = 1'b1;
        step();
        crash_in = 1'b0;
        total++; if ({alive, crashed} !== 2'b01) begin bad++; $display("FAIL grace_crash got=%b want=01", {alive, crashed}); end
        err = 0;
        repeat (80) begin
            step();
            if (move_strobe !== 1'b0 || pos_addr !== 32'd128102 || crashed !== 1'b1) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL crash_frozen got=%0d bad cycles want=0 (pos=%0d)", err, pos_addr); end
    endtask

    task automatic test_pause;
        int n, err;
        enable = 1'b0;
        respawn = 1'b1;
        step();
        respawn = 1'b0;
        step();
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        err = 0;
        repeat (10) begin
            step();
            if (move_strobe !== 1'b0 || pos_addr !== 32'd128100 || orient !== 32'd4) err++;
        end
        total++; if (err != 0) begin bad++; $display("FAIL pause_stable got=%0d bad cycles want=0", err); end
        enable = 1'b1;
        wait_strobe(20, n);
        total++; if (n != 3) begin bad++; $display("FAIL pause_resume_latency got=%0d want=3", n); end
        total++; if (pos_addr !== 32'd128101) begin bad++; $display("FAIL pause_pos got=%0d want=128101", pos_addr); end
    endtask

    initial begin
        test_reset();
        test_boundary();
        test_first_step();
        test_turn();
        test_respawn_priority();
        test_grace();
        test_pause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
